// File: rtl/bm_pkg.sv
// Shared definitions for the key hashing front end of main_one: op codes,
// default widths and seeds, and the packed command layout.
package bm_pkg;

  localparam logic [1:0] OP_INSERT = 2'b11;
  localparam logic [1:0] OP_QUERY  = 2'b10;

  localparam int KEY_W_DEF   = 32;
  localparam int ADDR_W_DEF  = 20;
  localparam int FP_W_DEF    = 8;
  localparam int CMD_LEN_DEF = 30;

  localparam logic [31:0] SEED_A_DEF = 32'h9E3779B1;
  localparam logic [31:0] SEED_B_DEF = 32'h85EBCA77;

  typedef struct packed {
    logic [1:0]            op;
    logic [ADDR_W_DEF-1:0] addr;
    logic [FP_W_DEF-1:0]   fp;
  } cmd_t;

endpackage

// File: rtl/mul_hash.sv
// Registered multiplicative hash: low 32 bits of key * SEED, loaded on en.
module mul_hash #(
  parameter int          KEY_W = 32,
  parameter logic [31:0] SEED  = 32'h9E3779B1
) (
  input  logic             clk,
  input  logic             en,
  input  logic [KEY_W-1:0] key,
  output logic [31:0]      hash
);

  logic [31:0] key32;

  generate
    if (KEY_W >= 32) begin : g_trunc
      assign key32 = key[31:0];
    end else begin : g_ext
      assign key32 = {{(32-KEY_W){1'b0}}, key};
    end
  endgenerate

  // Product register; only the low half of the product is ever needed
  always_ff @(posedge clk) begin
    if (en) hash <= key32 * SEED;
  end

endmodule

// File: rtl/key_cmd_hasher.sv
// Key-to-command hasher feeding main_one. Three-stage valid/ready pipeline:
// S1 captures key/op, S2 forms the two multiplicative hashes, S3 slices out
// the bucket address and a nonzero fingerprint. Bubbles collapse under stall.
// Optional statistics counters are built when CMD_STATS_EN is defined.
module key_cmd_hasher
  import bm_pkg::*;
#(
  parameter int          KEY_W   = KEY_W_DEF,
  parameter int          ADDR_W  = ADDR_W_DEF,
  parameter int          FP_W    = FP_W_DEF,
  parameter int          CMD_LEN = CMD_LEN_DEF,
  parameter logic [31:0] SEED_A  = SEED_A_DEF,
  parameter logic [31:0] SEED_B  = SEED_B_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_in_valid,
  output logic               key_in_ready,
  input  logic [1:0]         key_op,
  input  logic [KEY_W-1:0]   key_in,
  input  logic               stall_in,
  output logic               cmd_out_valid,
  output logic [CMD_LEN-1:0] cmd_out
`ifdef CMD_STATS_EN
  ,
  output logic [31:0]        ins_cnt,
  output logic [31:0]        qry_cnt,
  output logic [31:0]        stall_cycles
`endif
);

  generate
    if (CMD_LEN != 2 + ADDR_W + FP_W) begin : g_len_chk
      $error("CMD_LEN must equal 2+ADDR_W+FP_W");
    end
  endgenerate

  // Zero marks an empty slot downstream, so a zero fingerprint becomes 1
  function automatic logic [FP_W-1:0] fp_fix(input logic [FP_W-1:0] fp);
    return (fp == '0) ? FP_W'(1) : fp;
  endfunction

  logic               vld_p0, vld_p1, vld_p2;
  logic               ld_p0, ld_p1, ld_p2;
  logic [KEY_W-1:0]   key_p0;
  logic [1:0]         op_p0, op_p1;
  logic [31:0]        pa_p1, pb_p1;
  logic [CMD_LEN-1:0] cmd_p2;
  logic               unused_lo;

  // A stage loads when it is empty or its contents move on this cycle
  assign ld_p2        = !vld_p2 || !stall_in;
  assign ld_p1        = !vld_p1 || ld_p2;
  assign ld_p0        = !vld_p0 || ld_p1;
  assign key_in_ready = ld_p0;

  assign cmd_out_valid = vld_p2 && !stall_in;
  assign cmd_out       = vld_p2 ? cmd_p2 : '0;

  assign unused_lo = ^{pa_p1[31-ADDR_W:0], pb_p1[31-FP_W:0]};

  // Valid chain; the only state that needs reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (ld_p0) vld_p0 <= key_in_valid;
      if (ld_p1) vld_p1 <= vld_p0;
      if (ld_p2) vld_p2 <= vld_p1;
    end
  end

  // ---- S1: capture key and op ----
  always_ff @(posedge clk) begin
    if (ld_p0 && key_in_valid) begin
      key_p0 <= key_in;
      op_p0  <= key_op;
    end
  end

  // ---- S2: address and fingerprint hashes ----
  mul_hash #(.KEY_W(KEY_W), .SEED(SEED_A)) u_hash_a (
    .clk  (clk),
    .en   (ld_p1 && vld_p0),
    .key  (key_p0),
    .hash (pa_p1)
  );

  mul_hash #(.KEY_W(KEY_W), .SEED(SEED_B)) u_hash_b (
    .clk  (clk),
    .en   (ld_p1 && vld_p0),
    .key  (key_p0),
    .hash (pb_p1)
  );

  // Op rides alongside the hashes
  always_ff @(posedge clk) begin
    if (ld_p1 && vld_p0) op_p1 <= op_p0;
  end

  // ---- S3: slice top bits into {op, addr, fp}; held while stalled ----
  always_ff @(posedge clk) begin
    if (ld_p2 && vld_p1)
      cmd_p2 <= {op_p1, pa_p1[31 -: ADDR_W], fp_fix(pb_p1[31 -: FP_W])};
  end

`ifdef CMD_STATS_EN
  // Emitted insert/query counts and cycles spent holding a stalled command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ins_cnt      <= '0;
      qry_cnt      <= '0;
      stall_cycles <= '0;
    end else begin
      if (cmd_out_valid && cmd_p2[CMD_LEN-1 -: 2] == OP_INSERT) ins_cnt <= ins_cnt + 32'd1;
      if (cmd_out_valid && cmd_p2[CMD_LEN-1 -: 2] == OP_QUERY)  qry_cnt <= qry_cnt + 32'd1;
      if (vld_p2 && stall_in) stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_key_cmd_hasher.sv
// Self-checking bench for key_cmd_hasher with a queue-based reference model.
module tb_key_cmd_hasher;
  import bm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_in_valid;
  logic        key_in_ready;
  logic [1:0]  key_op;
  logic [31:0] key_in;
  logic        stall_in;
  logic        cmd_out_valid;
  logic [29:0] cmd_out;
`ifdef CMD_STATS_EN
  logic [31:0] ins_cnt, qry_cnt, stall_cycles;
`endif

  int checks = 0;
  int errors = 0;
  logic [29:0] acc_q[$];
  logic [29:0] got_q[$];

  key_cmd_hasher dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_in_valid  (key_in_valid),
    .key_in_ready  (key_in_ready),
    .key_op        (key_op),
    .key_in        (key_in),
    .stall_in      (stall_in),
    .cmd_out_valid (cmd_out_valid),
    .cmd_out       (cmd_out)
`ifdef CMD_STATS_EN
    ,
    .ins_cnt       (ins_cnt),
    .qry_cnt       (qry_cnt),
    .stall_cycles  (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Expected command straight from the hashing rules
  function automatic logic [29:0] ref_cmd(input logic [1:0] op, input logic [31:0] key);
    logic [31:0] pa, pb;
    cmd_t c;
    pa = key * 32'h9E3779B1;
    pb = key * 32'h85EBCA77;
    c.op   = op;
    c.addr = 20'(pa / 32'd4096);
    c.fp   = 8'(pb / 32'h0100_0000);
    if (c.fp == 8'd0) c.fp = 8'd1;
    return c;
  endfunction

  // Every accepted key produces one expected command, in order
  always @(posedge clk)
    if (rst_n && key_in_valid && key_in_ready) acc_q.push_back(ref_cmd(key_op, key_in));

  // Every emitted command is collected
  always @(negedge clk)
    if (rst_n && cmd_out_valid) got_q.push_back(cmd_out);

  function automatic int first_diff();
    for (int i = 0; i < acc_q.size() && i < got_q.size(); i++)
      if (acc_q[i] !== got_q[i]) return i;
    return -1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; key_in_valid = 1'b0; key_op = 2'b00; key_in = '0; stall_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    acc_q.delete(); got_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key_in_valid = 1'b0; key_op = 2'b00; key_in = '0; stall_in = 1'b0;
    #2;
    checks++; if (cmd_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", cmd_out_valid); end
    checks++; if (cmd_out !== 30'd0) begin errors++; $display("FAIL reset_cmd got %h exp 0", cmd_out); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (key_in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", key_in_ready); end
    checks++; if (cmd_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_rel got %b exp 0", cmd_out_valid); end
  endtask

  task automatic single_key(input logic [1:0] op, input logic [31:0] key,
                            input logic [29:0] exp, input string name);
    do_reset();
    @(posedge clk); #1 key_in = key; key_op = op; key_in_valid = 1'b1;
    @(posedge clk); #1 key_in_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      checks++;
      if (cmd_out_valid !== (i == 3)) begin
        errors++; $display("FAIL %s_valid cyc %0d got %b exp %b", name, i, cmd_out_valid, (i == 3));
      end
      if (i == 3) begin
        checks++;
        if (cmd_out !== exp) begin errors++; $display("FAIL %s_cmd got %h exp %h", name, cmd_out, exp); end
      end
    end
  endtask

  task automatic test_single();
    logic [29:0] exp;
    exp = {2'b11, 20'h9E377, 8'h85};
    single_key(2'b11, 32'd1, exp, "single");
  endtask

  task automatic test_fp_zero();
    logic [29:0] exp;
    exp = {2'b10, 20'h00000, 8'h01};
    single_key(2'b10, 32'd0, exp, "fp_zero");
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    do_reset();
    @(posedge clk); #1;
    for (int c = 0; c < 60; c++) begin
      if (c < 53) begin
        key_in = 32'(c + 1); key_op = 2'($urandom_range(0, 3)); key_in_valid = 1'b1;
      end else key_in_valid = 1'b0;
      @(negedge clk);
      if (c < 53) begin
        checks++;
        if (key_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready cyc %0d got %b exp 1", c, key_in_ready); end
      end
      exp_v = (c >= 3 && c <= 55);
      checks++;
      if (cmd_out_valid !== exp_v) begin errors++; $display("FAIL b2b_valid cyc %0d got %b exp %b", c, cmd_out_valid, exp_v); end
      @(posedge clk); #1;
    end
    checks++; if (got_q.size() != 53) begin errors++; $display("FAIL b2b_count got %0d exp 53", got_q.size()); end
    checks++; if (first_diff() != -1) begin errors++; $display("FAIL b2b_order idx %0d got %h exp %h", first_diff(), got_q[first_diff()], acc_q[first_diff()]); end
  endtask

  task automatic test_stall();
    logic will_acc;
    do_reset();
    @(posedge clk); #1 stall_in = 1'b1; key_in_valid = 1'b1; key_in = $urandom; key_op = 2'($urandom_range(0, 3));
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      if (c >= 3 && c <= 12) begin
        checks++;
        if (key_in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready cyc %0d got %b exp 0", c, key_in_ready); end
        checks++;
        if (cmd_out_valid !== 1'b0) begin errors++; $display("FAIL stall_valid cyc %0d got %b exp 0", c, cmd_out_valid); end
        checks++;
        if (cmd_out !== acc_q[0]) begin errors++; $display("FAIL stall_hold cyc %0d got %h exp %h", c, cmd_out, acc_q[0]); end
      end
      will_acc = key_in_ready;
      @(posedge clk); #1;
      if (c == 12) stall_in = 1'b0;
      if (will_acc) begin key_in = $urandom; key_op = 2'($urandom_range(0, 3)); end
    end
    key_in_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    checks++; if (got_q.size() != acc_q.size()) begin errors++; $display("FAIL stall_count got %0d exp %0d", got_q.size(), acc_q.size()); end
    checks++; if (first_diff() != -1) begin errors++; $display("FAIL stall_order idx %0d got %h exp %h", first_diff(), got_q[first_diff()], acc_q[first_diff()]); end
  endtask

  task automatic test_random();
    int zero_fp;
    do_reset();
    @(posedge clk); #1;
    for (int c = 0; c < 300; c++) begin
      key_in_valid = ($urandom_range(0, 3) != 0);
      stall_in     = ($urandom_range(0, 2) == 0);
      key_in       = $urandom;
      key_op       = 2'($urandom_range(0, 3));
      @(negedge clk);
      if (stall_in) begin
        checks++;
        if (cmd_out_valid !== 1'b0) begin errors++; $display("FAIL rand_stall_valid cyc %0d got %b exp 0", c, cmd_out_valid); end
      end
      @(posedge clk); #1;
    end
    key_in_valid = 1'b0; stall_in = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    checks++; if (got_q.size() != acc_q.size()) begin errors++; $display("FAIL rand_count got %0d exp %0d", got_q.size(), acc_q.size()); end
    checks++; if (first_diff() != -1) begin errors++; $display("FAIL rand_order idx %0d got %h exp %h", first_diff(), got_q[first_diff()], acc_q[first_diff()]); end
    zero_fp = 0;
    foreach (got_q[i]) if (got_q[i][7:0] == 8'd0) zero_fp++;
    checks++; if (zero_fp != 0) begin errors++; $display("FAIL rand_fp_nonzero got %0d zero fps exp 0", zero_fp); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(posedge clk); #1 stall_in = 1'b0; key_in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      key_in = $urandom; key_op = 2'($urandom_range(0, 3));
      if (c < 3) begin @(posedge clk); #1; end
    end
    @(negedge clk);
    checks++; if (cmd_out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b exp 1", cmd_out_valid); end
    rst_n = 1'b0; key_in_valid = 1'b0;
    #1;
    checks++; if (cmd_out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid got %b exp 0", cmd_out_valid); end
    checks++; if (cmd_out !== 30'd0) begin errors++; $display("FAIL mid_async_cmd got %h exp 0", cmd_out); end
    @(posedge clk); #1 rst_n = 1'b1;
    acc_q.delete(); got_q.delete();
    repeat (8) @(posedge clk);
    @(negedge clk);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL mid_stale got %0d cmds exp 0", got_q.size()); end
  endtask

`ifdef CMD_STATS_EN
  task automatic test_stats();
    logic [1:0] ops [4];
    ops = '{2'b11, 2'b10, 2'b11, 2'b10};
    do_reset();
    @(posedge clk); #1 stall_in = 1'b1; key_in_valid = 1'b1; key_op = 2'b11; key_in = $urandom;
    @(posedge clk); #1 key_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    repeat (4) @(posedge clk);
    #1 stall_in = 1'b0;
    for (int j = 0; j < 4; j++) begin
      key_op = ops[j]; key_in = $urandom; key_in_valid = 1'b1;
      @(posedge clk); #1;
    end
    key_in_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    checks++; if (ins_cnt !== 32'd3) begin errors++; $display("FAIL stats_ins got %0d exp 3", ins_cnt); end
    checks++; if (qry_cnt !== 32'd2) begin errors++; $display("FAIL stats_qry got %0d exp 2", qry_cnt); end
    checks++; if (stall_cycles !== 32'd4) begin errors++; $display("FAIL stats_stall got %0d exp 4", stall_cycles); end
    checks++; if (got_q.size() != 5) begin errors++; $display("FAIL stats_count got %0d exp 5", got_q.size()); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_fp_zero();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_mid();
`ifdef CMD_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_cmd_hasher.md
Name: key_cmd_hasher

Overview:
- Upstream stage of main_one.
- Accepts raw keys with an op code and hashes each key into a bucket address and a nonzero fingerprint.
- Emits 30-bit commands {op[1:0], addr[19:0], fp[7:0]} on the cmd_in_valid/cmd_in interface that main_one consumes.
- 3-stage valid/ready pipeline; backpressure from a downstream stall_in is absorbed without loss.

Parameters:
- KEY_W, 32, key width.
- ADDR_W, 20, bucket address width.
- FP_W, 8, fingerprint width.
- CMD_LEN, 30, output command width; must equal 2+ADDR_W+FP_W (elaboration-time assertion).
- SEED_A, 32'h9E3779B1, multiplier for the address hash.
- SEED_B, 32'h85EBCA77, multiplier for the fingerprint hash.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- key_in_valid  in  1  key/op valid.
- key_in_ready  out  1  stage can accept key this cycle.
- key_op  in  2  op: 2'b11 insert, 2'b10 query, others passed through unchanged.
- key_in  in  KEY_W  key.
- stall_in  in  1  downstream cannot take a command this cycle.
- cmd_out_valid  out  1  drives main_one cmd_in_valid.
- cmd_out  out  CMD_LEN  drives main_one cmd_in.

Behaviour:
- Reset (async assert, sync release): all stage valids = 0, cmd_out_valid = 0, cmd_out = 0, key_ready = 1 after release. Data registers need no reset.
- Transfer occurs when key_in_valid && key_in_ready.
- Pipeline stages:
  - S1 registers key, op.
  - S2 computes pa = (key*SEED_A) mod 2^32 and pb = (key*SEED_B) mod 2^32 (low 32 bits only).
  - S3 computes addr = pa[31:32-ADDR_W], fp = pb[31:32-FP_W]; if fp == 0 then fp = 1.
- Fingerprint is never 0 on the output: 0 is the empty-slot marker in main_one.
- Output: cmd_out_valid = S3.valid && !stall_in; cmd_out = {op, addr, fp} held stable while S3 is valid and stalled.
- Stage advance rule: stage k loads when stage k is empty or stage k is advancing. S3 advances when !stall_in. Bubbles collapse, so a stall with empty downstream stages still accepts input.
- key_in_ready = !S1.valid || S1 advancing (combinational from stall_in through the valid chain; no combinational path from key_in_valid).
- Latency: 3 cycles from accepted key to cmd_out_valid with stall_in = 0. Throughput 1 per cycle.
- Stall of N cycles with a full pipe: no drop, no duplicate; order preserved; 3 commands buffered max.
- Simultaneous accept and emit on a full pipe: allowed, occupancy unchanged.
- Reset mid-operation: all in-flight commands discarded; cmd_out_valid drops immediately (async).
- Op codes other than 11/10 are hashed and forwarded identically.

Optional Feature:
- Macro CMD_STATS_EN.
- With macro defined: adds outputs ins_cnt[31:0], qry_cnt[31:0] and stall_cycles[31:0].
  - ins_cnt increments on each emitted cmd with op 11.
  - qry_cnt increments on each emitted cmd with op 10.
  - stall_cycles increments each cycle S3 is valid and stall_in = 1.
  - All counters reset to 0 and wrap at 2^32.
- Without macro: ports and logic absent; hashing behaviour identical.

Decomposition:
- Shared package bm_pkg holds:
  - op localparams OP_INSERT = 2'b11, OP_QUERY = 2'b10.
  - ADDR_W, FP_W, CMD_LEN defaults.
  - packed struct cmd_t {op, addr, fp}.
  - default seeds.
- One sub-module: mul_hash, a registered KEY_W x 32 low-half multiplier with enable. Instantiated twice (SEED_A, SEED_B) in S2.

Test Plan:
- Reset then key_in = 1, op 11, stall_in = 0 -> 3 cycles later cmd_out_valid = 1, cmd_out = {2'b11, 20'h9E377, 8'h85}, for exactly 1 cycle.
- key_in = 0, op 10 -> cmd_out = {2'b10, 20'h00000, 8'h01} (fp remap from 0).
- Stream 53 back-to-back keys (1..53) with stall_in = 0 -> 53 consecutive valid cycles, in input order, key_in_ready constantly 1.
- Full pipe, hold stall_in = 1 for 10 cycles -> key_in_ready = 0 and cmd_out stable throughout. On release, 3 buffered cmds emit in order, then resume; total out = total accepted.
- Assert rst_n = 0 with 3 in flight -> cmd_out_valid = 0 immediately; after release no stale command appears.
- With CMD_STATS_EN: 3 inserts, 2 queries, 4-cycle stall on a valid S3 -> ins_cnt = 3, qry_cnt = 2, stall_cycles = 4.
